// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants for the sprite ROM readers and ROM wrappers.
//   - Default sprite tile size (34x36 foam/bee tiles, 8-bit pixels)
//   - VGA 640x480 raster totals and visible extents
//   - Transparent colour key
//   - addr_w_for(): ROM address width needed to hold a w x h tile
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int SPR_W_DEFAULT   = 34;
    localparam int SPR_H_DEFAULT   = 36;

    localparam int H_TOTAL_DEFAULT = 800;
    localparam int V_TOTAL_DEFAULT = 525;
    localparam int H_VISIBLE       = 640;
    localparam int V_VISIBLE       = 480;

    localparam logic [7:0] TRANSP_KEY_DEFAULT = 8'h00;

    localparam int DEF_X_DEFAULT   = 300;
    localparam int DEF_Y_DEFAULT   = 220;

    // Smallest address width whose range covers every pixel of a w x h tile.
    function automatic int addr_w_for(input int w, input int h);
        return ((w * h) <= 1) ? 1 : $clog2(w * h);
    endfunction

    localparam int ADDR_W_DEFAULT  = addr_w_for(SPR_W_DEFAULT, SPR_H_DEFAULT);

endpackage

// File: rtl/sprite_box_hit.sv
// -----------------------------------------------------------------------------
// sprite_box_hit
// Combinational "is (x,y) inside the sprite box" test plus the column offset
// of x inside the box. Also usable for sprite/sprite collision checks.
// Ports:
//   x, y         : pixel coordinate under test
//   box_x, box_y : top-left corner of the box
//   hit          : 1 when box_x <= x < box_x+SPR_W and box_y <= y < box_y+SPR_H
//   col_off      : x - box_x, meaningful only when hit=1
// -----------------------------------------------------------------------------
module sprite_box_hit
    import sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEFAULT,
    parameter int SPR_H = SPR_H_DEFAULT,
    parameter int OFF_W = ADDR_W_DEFAULT
) (
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [9:0]       box_x,
    input  logic [9:0]       box_y,
    output logic             hit,
    output logic [OFF_W-1:0] col_off
);

    // One extra bit so a box whose right/bottom edge passes 1023 does not
    // wrap around and falsely match small coordinates.
    logic [10:0] x_e;
    logic [10:0] y_e;
    logic [10:0] bx_e;
    logic [10:0] by_e;

    always_comb begin
        x_e     = {1'b0, x};
        y_e     = {1'b0, y};
        bx_e    = {1'b0, box_x};
        by_e    = {1'b0, box_y};
        hit     = (x_e >= bx_e) && (x_e < (bx_e + 11'(SPR_W))) &&
                  (y_e >= by_e) && (y_e < (by_e + 11'(SPR_H)));
        col_off = OFF_W'(x_e - bx_e);
    end

endmodule

// File: rtl/sprite_rom_reader.sv
// -----------------------------------------------------------------------------
// sprite_rom_reader
// Read side of a single-port sprite ROM with a registered 1-clock read.
// Decides whether the current raster pixel lies in the sprite box, issues the
// ROM address, and re-aligns the returned pixel with its strobe.
// Ports:
//   i_clk2         : system clock
//   i_rst_n        : asynchronous active-low reset
//   i_pix_stb      : one-clock pixel strobe, i_x/i_y valid in that cycle
//   i_x, i_y       : current raster coordinate
//   i_frame_start  : one-clock pulse in vertical blank, loads i_spr_x/i_spr_y
//   i_spr_x/_y     : requested sprite top-left (shadow position)
//   o_rom_addr     : registered ROM address
//   i_rom_data     : ROM data, valid one clock after o_rom_addr changes
//   o_pix_data     : sprite colour (0 outside the box)
//   o_pix_on       : pixel inside the box and not the transparent key
//   o_pix_valid    : one-clock pulse when o_pix_data/o_pix_on update
//
// Strobe/valid semantics: every cycle with i_pix_stb=1 produces exactly one
// o_pix_valid pulse three clocks later, in order; there is no back-pressure,
// so strobes may arrive on consecutive clocks. o_pix_data/o_pix_on are only
// meaningful in the o_pix_valid cycle and hold their value otherwise.
// -----------------------------------------------------------------------------
module sprite_rom_reader
    import sprite_pkg::*;
#(
    parameter int         SPR_W      = SPR_W_DEFAULT,
    parameter int         SPR_H      = SPR_H_DEFAULT,
    parameter int         ADDR_W     = ADDR_W_DEFAULT,
    parameter int         H_TOTAL    = H_TOTAL_DEFAULT,
    parameter int         V_TOTAL    = V_TOTAL_DEFAULT,
    parameter logic [7:0] TRANSP_KEY = TRANSP_KEY_DEFAULT,
    parameter int         DEF_X      = DEF_X_DEFAULT,
    parameter int         DEF_Y      = DEF_Y_DEFAULT
) (
    input  logic              i_clk2,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic              i_frame_start,
    input  logic [9:0]        i_spr_x,
    input  logic [9:0]        i_spr_y,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [7:0]        o_pix_data,
    output logic              o_pix_on,
    output logic              o_pix_valid
);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

    // Active (frame-stable) sprite position.
    logic [9:0]        act_x;
    logic [9:0]        act_y;

    // Address of the first pixel of the sprite row for the current line.
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_next;
    logic [9:0]        y_next;
    logic [10:0]       y_diff;

    logic              inbox;
    logic [ADDR_W-1:0] col_off;

    // Pipeline tags: v* = a strobe is in flight, b* = it was inside the box.
    logic              v1;
    logic              b1;
    logic              v2;
    logic              b2;

    // -------------------------------------------------------------------------
    // Position double buffer: the sprite only moves at frame boundaries.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_x <= 10'(DEF_X);
            act_y <= 10'(DEF_Y);
        end else if (i_frame_start) begin
            act_x <= i_spr_x;
            act_y <= i_spr_y;
        end
    end

    // -------------------------------------------------------------------------
    // Row base for the next line, prepared on the last strobe of each line so
    // the address path only needs an add. Low ADDR_W bits of the product only
    // depend on low ADDR_W bits of the operands; a negative y_diff means the
    // next line is above the box and the value is never used.
    // -------------------------------------------------------------------------
    always_comb begin
        y_next        = (i_y == Y_LAST) ? 10'd0 : (i_y + 10'd1);
        y_diff        = {1'b0, y_next} - {1'b0, act_y};
        row_base_next = ADDR_W'(y_diff) * ADDR_W'(SPR_W);
    end

    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_base <= '0;
        end else if (i_pix_stb && (i_x == X_LAST)) begin
            row_base <= row_base_next;
        end
    end

    // -------------------------------------------------------------------------
    // S0: box test and address issue. Uses the position and row base as they
    // stand before this edge, so a same-cycle frame start or row-base update
    // only affects later strobes.
    // -------------------------------------------------------------------------
    sprite_box_hit #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .OFF_W (ADDR_W)
    ) u_box_hit (
        .x       (i_x),
        .y       (i_y),
        .box_x   (act_x),
        .box_y   (act_y),
        .hit     (inbox),
        .col_off (col_off)
    );

    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rom_addr <= '0;
            v1         <= 1'b0;
            b1         <= 1'b0;
        end else begin
            v1 <= i_pix_stb;
            b1 <= i_pix_stb && inbox;
            // Outside the box the address is left alone: the data is masked
            // later anyway and a quiet bus saves ROM toggling.
            if (i_pix_stb && inbox) begin
                o_rom_addr <= row_base + col_off;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S1: ROM is sampling o_rom_addr; carry the tags one stage.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2 <= 1'b0;
            b2 <= 1'b0;
        end else begin
            v2 <= v1;
            b2 <= b1;
        end
    end

    // -------------------------------------------------------------------------
    // S2: ROM data is valid; mask it outside the box and flag transparency.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix_data  <= 8'h00;
            o_pix_on    <= 1'b0;
            o_pix_valid <= 1'b0;
        end else begin
            o_pix_valid <= v2;
            if (v2) begin
                o_pix_data <= b2 ? i_rom_data : 8'h00;
                o_pix_on   <= b2 && (i_rom_data != TRANSP_KEY);
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_reader
// Bench for sprite_rom_reader with a registered-read ROM model, table-driven
// vectors, hand-written corner sequences and randomized strobes checked
// against a coordinate-level reference model.
// -----------------------------------------------------------------------------
module tb_sprite_rom_reader;
    import sprite_pkg::*;

    localparam int         SW  = 34;
    localparam int         SH  = 36;
    localparam int         AW  = 11;
    localparam int         HT  = 800;
    localparam int         VT  = 525;
    localparam logic [7:0] KEY = 8'h00;
    localparam int         EW  = 42;   // {due[31:0], known, on, data[7:0]}

    // ---------------- clock / reset / DUT ----------------
    logic          i_clk2        = 1'b0;
    logic          i_rst_n       = 1'b0;
    logic          i_pix_stb     = 1'b0;
    logic [9:0]    i_x           = '0;
    logic [9:0]    i_y           = '0;
    logic          i_frame_start = 1'b0;
    logic [9:0]    i_spr_x       = 10'd300;
    logic [9:0]    i_spr_y       = 10'd220;
    logic [AW-1:0] o_rom_addr;
    logic [7:0]    i_rom_data    = 8'h00;
    logic [7:0]    o_pix_data;
    logic          o_pix_on;
    logic          o_pix_valid;

    always #5 i_clk2 = ~i_clk2;

    sprite_rom_reader #(
        .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW), .H_TOTAL(HT), .V_TOTAL(VT),
        .TRANSP_KEY(KEY), .DEF_X(300), .DEF_Y(220)
    ) dut (
        .i_clk2(i_clk2), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
        .i_x(i_x), .i_y(i_y), .i_frame_start(i_frame_start),
        .i_spr_x(i_spr_x), .i_spr_y(i_spr_y), .o_rom_addr(o_rom_addr),
        .i_rom_data(i_rom_data), .o_pix_data(o_pix_data),
        .o_pix_on(o_pix_on), .o_pix_valid(o_pix_valid)
    );

    // ROM model: registered 1-clock read.
    logic [7:0] rom [0:2047];
    always @(posedge i_clk2) i_rom_data <= rom[o_rom_addr];

    int cyc = 0;
    always @(posedge i_clk2) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [7:0]      last_data;
    logic            last_on;

    // Reference model: active position and which line the DUT's row base was
    // last prepared for (and with which sprite top).
    int m_ax, m_ay;
    bit prep_ok;
    int prep_line, prep_ay;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: each queued strobe must pulse o_pix_valid at its due cycle.
    always @(negedge i_clk2) begin : mon
        logic [EW-1:0] e;
        int            due;
        if (i_rst_n) begin
            while (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL pix_valid_late actual=none expected=pulse@%0d", int'(e[41:10]));
            end
            due = (exp_q.size() > 0) ? int'(exp_q[0][41:10]) : -1;
            if (due == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (o_pix_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL pix_valid actual=%b expected=1 cyc=%0d", o_pix_valid, cyc);
                end else if (e[9]) begin
                    checks++;
                    if (o_pix_data !== e[7:0] || o_pix_on !== e[8]) begin
                        errors++;
                        $display("FAIL pix_out actual=%h/%b expected=%h/%b cyc=%0d",
                                 o_pix_data, o_pix_on, e[7:0], e[8], cyc);
                    end
                    last_data = e[7:0];
                    last_on   = e[8];
                end
            end else if (o_pix_valid !== 1'b0) begin
                checks++; errors++;
                $display("FAIL pix_valid_stray actual=%b expected=0 cyc=%0d", o_pix_valid, cyc);
            end
        end
    end

    // ---------------- driver tasks (all start/end at posedge+1) ----------------
    task automatic idle(input int n);
        i_pix_stb = 1'b0;
        repeat (n) @(posedge i_clk2);
        #1;
    endtask

    task automatic frame(input int nx, input int ny);
        i_frame_start = 1'b1;
        i_spr_x = 10'(nx);
        i_spr_y = 10'(ny);
        @(posedge i_clk2); #1;
        i_frame_start = 1'b0;
        m_ax = nx; m_ay = ny;
    endtask

    // One strobe with caller-supplied expectations.
    task automatic issue(input int x, input int y, input bit exp_in, input bit known,
                         input int exp_addr, input bit fs, input int nx, input int ny);
        logic [EW-1:0] ent;
        logic [7:0]    d;
        logic [AW-1:0] a;
        a   = AW'(exp_addr);
        d   = exp_in ? rom[a] : 8'h00;
        ent = {32'(cyc + 3), (!exp_in || known), (exp_in && d != KEY), d};
        exp_q.push_back(ent);
        i_x = 10'(x); i_y = 10'(y); i_pix_stb = 1'b1; i_frame_start = fs;
        if (fs) begin i_spr_x = 10'(nx); i_spr_y = 10'(ny); end
        @(posedge i_clk2); #1;
        i_pix_stb = 1'b0; i_frame_start = 1'b0;
        if (exp_in && known) chk($sformatf("rom_addr x=%0d y=%0d", x, y), 32'(o_rom_addr), 32'(exp_addr));
        if (x == HT - 1) begin
            prep_ok = 1'b1;
            prep_line = (y == VT - 1) ? 0 : y + 1;
            prep_ay = m_ay;
        end
        if (fs) begin m_ax = nx; m_ay = ny; end
    endtask

    // One strobe with expectations from the reference model.
    task automatic strobe(input int x, input int y);
        bit inb, known;
        inb   = (x >= m_ax) && (x < m_ax + SW) && (y >= m_ay) && (y < m_ay + SH);
        known = prep_ok && (prep_line == y) && (prep_ay == m_ay);
        issue(x, y, inb, known, (y - m_ay) * SW + (x - m_ax), 1'b0, 0, 0);
    endtask

    task automatic prep(input int y);
        strobe(HT - 1, (y == 0) ? VT - 1 : y - 1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_pix_stb = 1'b0; i_frame_start = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_rom_addr",  32'(o_rom_addr), 0);
        chk("rst_pix_data",  32'(o_pix_data), 0);
        chk("rst_pix_on",    32'(o_pix_on), 0);
        chk("rst_pix_valid", 32'(o_pix_valid), 0);
        repeat (2) @(posedge i_clk2);
        @(negedge i_clk2) i_rst_n = 1'b1;
        @(posedge i_clk2); #1;
        m_ax = 300; m_ay = 220;
        prep_ok = 1'b1; prep_line = 220; prep_ay = 220;   // row_base=0 is line ay
    endtask

    // ---------------- table ----------------
    typedef struct {
        int ax, ay, x, y;
        bit inbox;
        int addr;
    } vec_t;
    vec_t tab[14];

    initial begin
        int rx, ry, x;
        for (int i = 0; i < 2048; i++)
            rom[i] = ((i % 7) == 3) ? 8'h00 : 8'($urandom_range(1, 255));
        rom[0] = 8'h5A; rom[1223] = 8'h00; rom[53] = 8'h33; rom[68] = 8'h44;

        tab[0]  = '{300, 220, 300, 220, 1'b1, 0};
        tab[1]  = '{300, 220, 333, 255, 1'b1, 1223};
        tab[2]  = '{300, 220, 299, 220, 1'b0, 0};
        tab[3]  = '{300, 220, 334, 220, 1'b0, 0};
        tab[4]  = '{300, 220, 300, 256, 1'b0, 0};
        tab[5]  = '{300, 220, 300, 219, 1'b0, 0};
        tab[6]  = '{620, 220, 639, 221, 1'b1, 53};
        tab[7]  = '{620, 220, 0,   221, 1'b0, 0};
        tab[8]  = '{620, 220, 620, 222, 1'b1, 68};
        tab[9]  = '{1000, 500, 1023, 510, 1'b1, 363};
        tab[10] = '{1000, 500, 5,   510, 1'b0, 0};
        tab[11] = '{0,   0,   0,   0,   1'b1, 0};
        tab[12] = '{0,   0,   33,  35,  1'b1, 1223};
        tab[13] = '{790, 520, 799, 524, 1'b1, 145};

        // Reset and quiet period.
        repeat (3) @(posedge i_clk2);
        @(negedge i_clk2) i_rst_n = 1'b1;
        m_ax = 300; m_ay = 220;
        prep_ok = 1'b1; prep_line = 220; prep_ay = 220;
        repeat (20) @(posedge i_clk2);
        #1;
        chk("idle_rom_addr",  32'(o_rom_addr), 0);
        chk("idle_pix_data",  32'(o_pix_data), 0);
        chk("idle_pix_on",    32'(o_pix_on), 0);
        chk("idle_pix_valid", 32'(o_pix_valid), 0);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            if (tab[i].ax != m_ax || tab[i].ay != m_ay) frame(tab[i].ax, tab[i].ay);
            prep(tab[i].y);
            idle(1);
            issue(tab[i].x, tab[i].y, tab[i].inbox, 1'b1, tab[i].addr, 1'b0, 0, 0);
            idle(4);
        end

        // Shadow position ignored without frame start; same-cycle frame start.
        frame(300, 220);
        prep(220);
        i_spr_x = 10'd100;
        issue(100, 220, 1'b0, 1'b1, 0, 1'b0, 0, 0);
        issue(300, 220, 1'b1, 1'b1, 0, 1'b0, 0, 0);
        issue(300, 220, 1'b1, 1'b1, 0, 1'b1, 100, 220);
        issue(100, 220, 1'b1, 1'b1, 0, 1'b0, 0, 0);
        issue(300, 220, 1'b0, 1'b1, 0, 1'b0, 0, 0);
        idle(5);

        // Back-to-back burst, then hold check.
        frame(300, 220);
        prep(220);
        idle(2);
        for (int xx = 298; xx <= 303; xx++)
            issue(xx, 220, (xx >= 300), 1'b1, xx - 300, 1'b0, 0, 0);
        idle(8);
        chk("hold_pix_data", 32'(o_pix_data), 32'(rom[3]));
        chk("hold_pix_on",   32'(o_pix_on), 32'(rom[3] != KEY));

        // Reset in the middle of a burst at a non-default position.
        frame(500, 100);
        prep(100);
        for (int xx = 498; xx <= 501; xx++) strobe(xx, 100);
        do_reset();
        idle(10);
        issue(301, 220, 1'b1, 1'b1, 1, 1'b0, 0, 0);   // default position and row base
        idle(5);

        // Randomized strobes against the reference model.
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 3) != 0)
                frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 524)));
            ry = (m_ay + VT - 2 + int'($urandom_range(0, 41))) % VT;
            prep(ry);
            for (int k = 0; k < 8; k++) begin
                rx = m_ax - 3 + int'($urandom_range(0, 40));
                x  = (rx > HT - 1) ? int'($urandom_range(0, HT - 1)) : ((rx < 0) ? 0 : rx);
                strobe(x, ry);
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            end
        end

        idle(10);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
